skeleton_thinning_engine: RTL and testbench

// - Parametrised successor to the single-pass image/mask controller. Owns a binary image store, a load path, and a

---
 rtl/skel_pkg.sv | 33 +++
 rtl/zs_neighbour_eval.sv | 50 +++++
 rtl/skeleton_thinning_engine.sv | 219 +++++++++++++++++++++
 tb/tb_skeleton_thinning_engine.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skel_pkg.sv
// Shared types and helpers for the skeleton thinning engine.
// State encoding, neighbour slot indices and width helpers.
package skel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Neighbour slots, clockwise from north.
  localparam int P2 = 0;
  localparam int P3 = 1;
  localparam int P4 = 2;
  localparam int P5 = 3;
  localparam int P6 = 4;
  localparam int P7 = 5;
  localparam int P8 = 6;
  localparam int P9 = 7;

  function automatic int f_addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  function automatic int f_cnt_w(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  function automatic int f_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zs_neighbour_eval.sv
// Zhang-Suen deletion test for one pixel.
// Pure combinational; shared by every SCAN cycle.
module zs_neighbour_eval
  import skel_pkg::*;
(
  input  logic [7:0] i_nb,
  input  logic       i_centre,
  input  logic       i_sub_iter,
  output logic       o_delete
);

  logic [3:0] w_b;
  logic [3:0] w_a;
  logic [7:0] w_rot;
  logic [7:0] w_rise;
  logic       w_sub0_ok;
  logic       w_sub1_ok;

  // Slot k+1 aligned under slot k, wrapping P9 back to P2.
  assign w_rot  = {i_nb[0], i_nb[7:1]};
  assign w_rise = ~i_nb & w_rot;

  // B = foreground neighbours, A = 0->1 transitions around the ring.
  always_comb begin
    w_b = '0;
    w_a = '0;
    for (int k = 0; k < 8; k++) begin
      w_b = w_b + 4'(i_nb[k]);
      w_a = w_a + 4'(w_rise[k]);
    end
  end

  assign w_sub0_ok =
    !(i_nb[P2] & i_nb[P4] & i_nb[P6]) &&
    !(i_nb[P4] & i_nb[P6] & i_nb[P8]);

  assign w_sub1_ok =
    !(i_nb[P2] & i_nb[P4] & i_nb[P8]) &&
    !(i_nb[P2] & i_nb[P6] & i_nb[P8]);

  // Final delete decision for the current sub-iteration.
  always_comb begin
    o_delete = 1'b0;
    if (i_centre && (w_b >= 4'd2) &&
        (w_b <= 4'd6) && (w_a == 4'd1)) begin
      o_delete = i_sub_iter ? w_sub1_ok : w_sub0_ok;
    end
  end

endmodule

// File: rtl/skeleton_thinning_engine.sv
// Binary image store with load path and multi-pass
// Zhang-Suen thinning sequencer running to convergence.
module skeleton_thinning_engine
  import skel_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int pixelWidth = 8,
  parameter int THRESHOLD  = 128,
  parameter int MAX_PASSES = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                we,
  input  logic [pixelWidth-1:0]               data_in,
  input  logic                                start,
  input  logic [f_addr_w(IMG_W,IMG_H)-1:0]    rd_addr,
  output logic                                rd_data,
  output logic                                loaded,
  output logic                                busy,
  output logic                                done,
  output logic                                max_hit,
  output logic                                wr_drop,
  output logic [f_cnt_w(MAX_PASSES)-1:0]      pass_count
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = f_addr_w(IMG_W, IMG_H);
  localparam int CNT_W  = f_cnt_w(MAX_PASSES);
  localparam int ROW_W  = f_idx_w(IMG_H);
  localparam int COL_W  = f_idx_w(IMG_W);
  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PASSES);
  localparam logic [pixelWidth-1:0] THR =
    pixelWidth'(THRESHOLD);

  state_t            r_state;
  state_t            w_state_nx;
  logic [NPIX-1:0]   r_img;
  logic [NPIX-1:0]   r_del;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_loaded;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic              r_sub;
  logic              r_any;
  logic [CNT_W-1:0]  r_pass;
  logic              r_max;
  logic              r_done;
  logic              r_drop;
  logic              r_rd;

  logic              w_start_ok;
  logic              w_ptr_last;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_last_px;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_nb;
  logic              w_centre;
  logic              w_del_px;
  logic              w_any;
  logic [CNT_W-1:0]  w_pass_nx;
  logic              w_finish;

  // Out-of-image neighbours read as background.
  function automatic logic f_px(
    input logic [NPIX-1:0] img,
    input int              r,
    input int              c
  );
    if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W)
      return 1'b0;
    return img[ADDR_W'(r * IMG_W + c)];
  endfunction

  assign w_start_ok = (r_state == IDLE) && start && r_loaded;
  assign w_ptr_last = (r_ptr == ADDR_W'(NPIX - 1));
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_last_px  = w_col_last && w_row_last;
  assign w_addr     =
    ADDR_W'(int'(r_row) * IMG_W + int'(r_col));
  assign w_centre   = r_img[w_addr];

  // Gather the 3x3 ring around the scan position.
  always_comb begin
    w_nb     = '0;
    w_nb[P2] = f_px(r_img, int'(r_row) - 1, int'(r_col));
    w_nb[P3] = f_px(r_img, int'(r_row) - 1, int'(r_col) + 1);
    w_nb[P4] = f_px(r_img, int'(r_row),     int'(r_col) + 1);
    w_nb[P5] = f_px(r_img, int'(r_row) + 1, int'(r_col) + 1);
    w_nb[P6] = f_px(r_img, int'(r_row) + 1, int'(r_col));
    w_nb[P7] = f_px(r_img, int'(r_row) + 1, int'(r_col) - 1);
    w_nb[P8] = f_px(r_img, int'(r_row),     int'(r_col) - 1);
    w_nb[P9] = f_px(r_img, int'(r_row) - 1, int'(r_col) - 1);
  end

  zs_neighbour_eval u_eval (
    .i_nb       (w_nb),
    .i_centre   (w_centre),
    .i_sub_iter (r_sub),
    .o_delete   (w_del_px)
  );

  assign w_any     = r_any | (|r_del);
  assign w_pass_nx = (r_pass == MAXP) ?
                     r_pass : r_pass + CNT_W'(1);
  assign w_finish  = (r_state == APPLY) && r_sub &&
                     (!w_any || (w_pass_nx == MAXP));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state decode.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_start_ok) w_state_nx = SCAN;
      SCAN:    if (w_last_px)  w_state_nx = APPLY;
      APPLY:   w_state_nx = w_finish ? IDLE : SCAN;
      default: w_state_nx = IDLE;
    endcase
  end

  // Image store, delete flags and load pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_img    <= '0;
      r_del    <= '0;
      r_ptr    <= '0;
      r_loaded <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_ptr    <= '0;
            r_loaded <= 1'b0;
          end else if (we) begin
            r_img[r_ptr] <= (data_in >= THR);
            r_ptr <= w_ptr_last ? '0 : r_ptr + ADDR_W'(1);
            if (w_ptr_last) r_loaded <= 1'b1;
          end
        end
        SCAN:  r_del[w_addr] <= w_del_px;
        APPLY: begin
          r_img <= r_img & ~r_del;
          r_del <= '0;
        end
        default: ;
      endcase
    end
  end

  // Raster scan position; parks at 0 outside SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (r_state == SCAN) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Sub-iteration, pass accounting and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub  <= 1'b0;
      r_any  <= 1'b0;
      r_pass <= '0;
      r_max  <= 1'b0;
      r_done <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_drop <= we && ((r_state != IDLE) || w_start_ok);
      if (w_start_ok) begin
        r_sub  <= 1'b0;
        r_any  <= 1'b0;
        r_pass <= '0;
        r_max  <= 1'b0;
      end else if (r_state == APPLY) begin
        if (!r_sub) begin
          r_sub <= 1'b1;
          r_any <= |r_del;
        end else begin
          r_sub  <= 1'b0;
          r_any  <= 1'b0;
          r_pass <= w_pass_nx;
          r_done <= w_finish;
          if (w_any && (w_pass_nx == MAXP)) r_max <= 1'b1;
        end
      end
    end
  end

  // Registered readback of the live image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd <= 1'b0;
    else if (int'(rd_addr) < NPIX) r_rd <= r_img[rd_addr];
    else r_rd <= 1'b0;
  end

  assign rd_data    = r_rd;
  assign loaded     = r_loaded;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign max_hit    = r_max;
  assign wr_drop    = r_drop;
  assign pass_count = r_pass;

endmodule

// File: tb/tb_skeleton_thinning_engine.sv
// Directed bench for skeleton_thinning_engine.
// Main instance runs to convergence; a second caps at one pass.
module tb_skeleton_thinning_engine;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = '0;
  logic [5:0] rd_addr = '0;
  logic       rd_data, loaded, busy, done, max_hit, wr_drop;
  logic [4:0] pass_count;

  logic       we1 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] data_in1 = '0;
  logic [5:0] rd_addr1 = '0;
  logic       rd_data1, loaded1, busy1, done1, max_hit1, wr_drop1;
  logic [0:0] pass_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skeleton_thinning_engine #(.MAX_PASSES(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .data_in(data_in),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .loaded(loaded), .busy(busy), .done(done),
    .max_hit(max_hit), .wr_drop(wr_drop),
    .pass_count(pass_count)
  );

  skeleton_thinning_engine #(.MAX_PASSES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we1), .data_in(data_in1),
    .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .loaded(loaded1), .busy(busy1), .done(done1),
    .max_hit(max_hit1), .wr_drop(wr_drop1),
    .pass_count(pass_count1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bar_frame();
    logic [63:0] b = '0;
    for (int r = 3; r <= 5; r++)
      for (int c = 1; c <= 6; c++) b[r*8+c] = 1'b1;
    return b;
  endfunction

  // Reference Zhang-Suen on a zero-padded 10x10 grid.
  function automatic void zs_model(
    input  logic [63:0] in,
    input  int          maxp,
    output logic [63:0] out,
    output int          passes
  );
    int g [10][10];
    int d [10][10];
    int p [10];
    int a, b, nx;
    bit ok, chg;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) g[r][c] = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) g[r+1][c+1] = int'(in[r*8+c]);
    passes = 0;
    do begin
      chg = 0;
      for (int s = 0; s < 2; s++) begin
        for (int r = 1; r <= 8; r++)
          for (int c = 1; c <= 8; c++) begin
            d[r][c] = 0;
            if (g[r][c] == 1) begin
              p[2] = g[r-1][c];   p[3] = g[r-1][c+1];
              p[4] = g[r][c+1];   p[5] = g[r+1][c+1];
              p[6] = g[r+1][c];   p[7] = g[r+1][c-1];
              p[8] = g[r][c-1];   p[9] = g[r-1][c-1];
              b = 0; a = 0;
              for (int k = 2; k <= 9; k++) begin
                nx = (k == 9) ? 2 : k + 1;
                b += p[k];
                if (p[k] == 0 && p[nx] == 1) a++;
              end
              if (s == 0)
                ok = (p[2]*p[4]*p[6] == 0) && (p[4]*p[6]*p[8] == 0);
              else
                ok = (p[2]*p[4]*p[8] == 0) && (p[2]*p[6]*p[8] == 0);
              if (b >= 2 && b <= 6 && a == 1 && ok) d[r][c] = 1;
            end
          end
        for (int r = 1; r <= 8; r++)
          for (int c = 1; c <= 8; c++)
            if (d[r][c] == 1) begin
              g[r][c] = 0;
              chg = 1;
            end
      end
      passes++;
    end while (chg && passes < maxp);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) out[r*8+c] = (g[r+1][c+1] != 0);
  endfunction

  task automatic load_frame(input logic [63:0] f);
    for (int i = 0; i < N; i++) begin
      we = 1'b1;
      data_in = f[i] ? 8'hFF : 8'h00;
      tick();
    end
    we = 1'b0;
    data_in = '0;
  endtask

  task automatic read_img(output logic [63:0] img);
    for (int a = 0; a < N; a++) begin
      rd_addr = 6'(a);
      tick();
      img[a] = rd_data;
    end
  endtask

  task automatic start_and_wait(output int n, output logic d);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      n++;
      tick();
    end
    d = done;
  endtask

  task automatic test_reset();
    logic [63:0] img;
    logic [10:0] outs;
    outs = {rd_data, loaded, busy, done, max_hit, wr_drop, pass_count};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", outs);
    end
    read_img(img);
    checks++;
    if (img !== '0) begin
      errors++;
      $display("FAIL reset_img got %h exp 0", img);
    end
    load_frame('1);
    checks++;
    if (loaded !== 1'b1) begin
      errors++;
      $display("FAIL reset_loaded_full got %b exp 1", loaded);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    outs = {rd_data, loaded, busy, done, max_hit, wr_drop, pass_count};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_midrun_outs got %h exp 0", outs);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release done=%b busy=%b exp 0 0",
               done, busy);
    end
    read_img(img);
    checks++;
    if (img !== '0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL reset_cleared img=%h loaded=%b exp 0 0",
               img, loaded);
    end
  endtask

  task automatic test_threshold();
    logic [63:0] img;
    for (int i = 0; i < N; i++) begin
      we = 1'b1;
      data_in = (i == 10) ? 8'd128 :
                (i == 11) ? 8'd127 :
                (i == 12) ? 8'd255 : 8'd0;
      tick();
    end
    we = 1'b0;
    read_img(img);
    checks++;
    if (img[12:10] !== 3'b101) begin
      errors++;
      $display("FAIL threshold got %b exp 101", img[12:10]);
    end
    checks++;
    if (loaded !== 1'b1) begin
      errors++;
      $display("FAIL threshold_loaded got %b exp 1", loaded);
    end
  endtask

  task automatic test_zeros();
    int n;
    logic d;
    logic [63:0] img;
    load_frame('0);
    start_and_wait(n, d);
    checks++;
    if (n != 130 || d !== 1'b1) begin
      errors++;
      $display("FAIL zeros_latency busy=%0d done=%b exp 130 1", n, d);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zeros_done_pulse got %b exp 0", done);
    end
    checks++;
    if (pass_count !== 5'd1 || max_hit !== 1'b0) begin
      errors++;
      $display("FAIL zeros_status pc=%0d mh=%b exp 1 0",
               pass_count, max_hit);
    end
    read_img(img);
    checks++;
    if (img !== '0) begin
      errors++;
      $display("FAIL zeros_img got %h exp 0", img);
    end
  endtask

  task automatic test_single();
    int n;
    logic d;
    logic [63:0] f, img;
    f = '0;
    f[27] = 1'b1;
    load_frame(f);
    start_and_wait(n, d);
    checks++;
    if (n != 130 || d !== 1'b1 || pass_count !== 5'd1) begin
      errors++;
      $display("FAIL single_run busy=%0d done=%b pc=%0d exp 130 1 1",
               n, d, pass_count);
    end
    read_img(img);
    checks++;
    if (img !== f) begin
      errors++;
      $display("FAIL single_img got %h exp %h", img, f);
    end
  endtask

  task automatic test_bar();
    int n, p;
    logic d;
    logic [63:0] f, exp_img, img;
    f = bar_frame();
    zs_model(f, 16, exp_img, p);
    load_frame(f);
    start_and_wait(n, d);
    checks++;
    if (n != 130 * p || d !== 1'b1) begin
      errors++;
      $display("FAIL bar_latency busy=%0d done=%b exp %0d 1",
               n, d, 130 * p);
    end
    checks++;
    if (int'(pass_count) != p || max_hit !== 1'b0) begin
      errors++;
      $display("FAIL bar_passes pc=%0d mh=%b exp %0d 0",
               pass_count, max_hit, p);
    end
    read_img(img);
    checks++;
    if (img !== exp_img) begin
      errors++;
      $display("FAIL bar_img got %h exp %h", img, exp_img);
    end
    checks++;
    if ((img & ~f) !== '0 || img === '0) begin
      errors++;
      $display("FAIL bar_subset got %h input %h", img, f);
    end
  endtask

  task automatic test_max_passes();
    int n, p;
    logic [63:0] f, exp_img, img;
    f = bar_frame();
    zs_model(f, 1, exp_img, p);
    for (int i = 0; i < N; i++) begin
      we1 = 1'b1;
      data_in1 = f[i] ? 8'hFF : 8'h00;
      tick();
    end
    we1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 4000) begin
      n++;
      tick();
    end
    checks++;
    if (n != 130 || done1 !== 1'b1) begin
      errors++;
      $display("FAIL maxp_latency busy=%0d done=%b exp 130 1",
               n, done1);
    end
    checks++;
    if (pass_count1 !== 1'b1 || max_hit1 !== 1'b1) begin
      errors++;
      $display("FAIL maxp_status pc=%0d mh=%b exp 1 1",
               pass_count1, max_hit1);
    end
    for (int a = 0; a < N; a++) begin
      rd_addr1 = 6'(a);
      tick();
      img[a] = rd_data1;
    end
    checks++;
    if (img !== exp_img) begin
      errors++;
      $display("FAIL maxp_img got %h exp %h", img, exp_img);
    end
  endtask

  task automatic test_misuse();
    int n;
    logic [63:0] img;
    for (int i = 0; i < 63; i++) begin
      we = 1'b1;
      data_in = 8'h00;
      tick();
    end
    we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL misuse_early_start busy=%b loaded=%b exp 0 0",
               busy, loaded);
    end
    we = 1'b1;
    tick();
    we = 1'b0;
    checks++;
    if (loaded !== 1'b1) begin
      errors++;
      $display("FAIL misuse_loaded got %b exp 1", loaded);
    end
    start = 1'b1;
    we = 1'b1;
    data_in = 8'hFF;
    tick();
    start = 1'b0;
    we = 1'b0;
    checks++;
    if (busy !== 1'b1 || wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL misuse_start_we busy=%b drop=%b exp 1 1",
               busy, wr_drop);
    end
    repeat (5) tick();
    we = 1'b1;
    tick();
    we = 1'b0;
    data_in = '0;
    checks++;
    if (wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL misuse_scan_we drop=%b exp 1", wr_drop);
    end
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      n++;
      tick();
    end
    checks++;
    if (done !== 1'b1 || pass_count !== 5'd1) begin
      errors++;
      $display("FAIL misuse_run done=%b pc=%0d exp 1 1",
               done, pass_count);
    end
    read_img(img);
    checks++;
    if (img !== '0) begin
      errors++;
      $display("FAIL misuse_img got %h exp 0", img);
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_threshold();
    test_zeros();
    test_single();
    test_bar();
    test_max_passes();
    test_misuse();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
